// File: rtl/vga_frame_reader.sv
// VGA 640x480@60 scan-out of a 160x120 RGB332 framebuffer, 4x4 replicated.
// Counters -> RAM address -> RAM data -> pins: 3-clock aligned pipeline.
module vga_frame_reader #(
   parameter int H_ACTIVE    = 640,
   parameter int H_FP        = 16,
   parameter int H_SYNC      = 96,
   parameter int H_BP        = 48,
   parameter int V_ACTIVE    = 480,
   parameter int V_FP        = 10,
   parameter int V_SYNC      = 2,
   parameter int V_BP        = 33,
   parameter int SCALE_SHIFT = 2,
   parameter int FB_W        = 160,
   parameter int AW          = 15
) (
   input  logic          clk,
   input  logic          rst,
   output logic [AW-1:0] fb_addr,
   output logic          fb_rd_en,
   input  logic [7:0]    fb_data,
   output logic [7:0]    r,
   output logic [7:0]    g,
   output logic [7:0]    b,
   output logic          h_sync,
   output logic          v_sync,
   output logic          sync_blank,
   output logic          sync_b,
   output logic          vblank,
   output logic          frame_start
);

   localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

   localparam logic [9:0] H_LAST = 10'(H_TOTAL - 1);
   localparam logic [9:0] V_LAST = 10'(V_TOTAL - 1);
   localparam logic [9:0] H_ACT  = 10'(H_ACTIVE);
   localparam logic [9:0] V_ACT  = 10'(V_ACTIVE);
   localparam logic [9:0] HS_BEG = 10'(H_ACTIVE + H_FP);
   localparam logic [9:0] HS_END = 10'(H_ACTIVE + H_FP + H_SYNC);
   localparam logic [9:0] VS_BEG = 10'(V_ACTIVE + V_FP);
   localparam logic [9:0] VS_END = 10'(V_ACTIVE + V_FP + V_SYNC);

   logic [9:0]    h_cnt;
   logic [9:0]    v_cnt;
   logic          active;
   logic          hs;
   logic          vs;
   logic [AW-1:0] row_w;
   logic [AW-1:0] col_w;
   logic [AW-1:0] addr_next;
   logic          act1, hs1, vs1;
   logic          act2, hs2, vs2;
   logic [7:0]    r_exp, g_exp, b_exp;

   always_ff @(posedge clk) begin
      if (!rst) begin
         h_cnt <= '0;
         v_cnt <= '0;
      end else if (h_cnt == H_LAST) begin
         h_cnt <= '0;
         v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + 10'd1;
      end else begin
         h_cnt <= h_cnt + 10'd1;
      end
   end

   assign active      = (h_cnt < H_ACT) && (v_cnt < V_ACT);
   assign hs          = !((h_cnt >= HS_BEG) && (h_cnt < HS_END));
   assign vs          = !((v_cnt >= VS_BEG) && (v_cnt < VS_END));
   assign vblank      = v_cnt >= V_ACT;
   assign frame_start = (h_cnt == 10'd0) && (v_cnt == 10'd0);
   assign sync_b      = 1'b0;

   assign row_w = AW'(v_cnt >> SCALE_SHIFT);
   assign col_w = AW'(h_cnt >> SCALE_SHIFT);

   // 160 = 128 + 32, so the row stride is two shifts and an add.
   generate
      if (FB_W == 160) begin : g_shift
         assign addr_next = (row_w << 7) + (row_w << 5) + col_w;
      end else begin : g_mul
         assign addr_next = AW'(row_w * AW'(FB_W)) + col_w;
      end
   endgenerate

   always_ff @(posedge clk) begin
      if (!rst) begin
         fb_addr  <= '0;
         fb_rd_en <= 1'b0;
         act1     <= 1'b0;
         hs1      <= 1'b1;
         vs1      <= 1'b1;
      end else begin
         fb_rd_en <= active;
         if (active) fb_addr <= addr_next;
         act1     <= active;
         hs1      <= hs;
         vs1      <= vs;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         act2 <= 1'b0;
         hs2  <= 1'b1;
         vs2  <= 1'b1;
      end else begin
         act2 <= act1;
         hs2  <= hs1;
         vs2  <= vs1;
      end
   end

   assign r_exp = {fb_data[7:5], fb_data[7:5], fb_data[7:6]};
   assign g_exp = {fb_data[4:2], fb_data[4:2], fb_data[4:3]};
   assign b_exp = {fb_data[1:0], fb_data[1:0], fb_data[1:0], fb_data[1:0]};

   always_ff @(posedge clk) begin
      if (!rst) begin
         r          <= '0;
         g          <= '0;
         b          <= '0;
         h_sync     <= 1'b1;
         v_sync     <= 1'b1;
         sync_blank <= 1'b0;
      end else begin
         r          <= act2 ? r_exp : 8'h00;
         g          <= act2 ? g_exp : 8'h00;
         b          <= act2 ? b_exp : 8'h00;
         h_sync     <= hs2;
         v_sync     <= vs2;
         sync_blank <= act2;
      end
   end

endmodule

// File: tb/tb_vga_frame_reader.sv
// Bench for vga_frame_reader: full-size instance for line timing and
// addressing, short-frame instance for vertical timing and frame wrap.
module tb_vga_frame_reader;

   logic clk = 1'b0;
   logic rst = 1'b0;

   logic [14:0] a_addr, b_addr;
   logic        a_en, b_en;
   logic [7:0]  a_data, b_data;
   logic [7:0]  a_r, a_g, a_b, b_r, b_g, b_b;
   logic        a_hs, a_vs, a_blank, a_sb, a_vbl, a_fs;
   logic        b_hs, b_vs, b_blank, b_sb, b_vbl, b_fs;

   logic [7:0]  mem [0:19199];
   logic [14:0] a_held, b_held;
   int          t = 0;
   logic        armed = 1'b0;
   int          checks = 0;
   int          errors = 0;

   always #5 clk = ~clk;

   vga_frame_reader dut_a (
      .clk(clk), .rst(rst), .fb_addr(a_addr), .fb_rd_en(a_en),
      .fb_data(a_data), .r(a_r), .g(a_g), .b(a_b),
      .h_sync(a_hs), .v_sync(a_vs), .sync_blank(a_blank),
      .sync_b(a_sb), .vblank(a_vbl), .frame_start(a_fs)
   );

   vga_frame_reader #(
      .V_ACTIVE(12), .V_FP(2), .V_SYNC(2), .V_BP(3)
   ) dut_b (
      .clk(clk), .rst(rst), .fb_addr(b_addr), .fb_rd_en(b_en),
      .fb_data(b_data), .r(b_r), .g(b_g), .b(b_b),
      .h_sync(b_hs), .v_sync(b_vs), .sync_blank(b_blank),
      .sync_b(b_sb), .vblank(b_vbl), .frame_start(b_fs)
   );

   initial begin
      for (int i = 0; i < 19200; i++) mem[i] = 8'(i * 37 + 11);
      mem[0] = 8'hE0;
      mem[1] = 8'h1C;
      mem[2] = 8'h03;
      mem[3] = 8'h92;
   end

   // Synchronous RAM; a bus with no read enable reads back all-ones.
   always @(posedge clk) begin
      a_data <= (a_en === 1'b1 && a_addr < 15'd19200) ? mem[a_addr] : 8'hFF;
      b_data <= (b_en === 1'b1 && b_addr < 15'd19200) ? mem[b_addr] : 8'hFF;
   end

   function automatic logic act_at(input int n, input int va, input int vt);
      int h, v;
      h = n % 800;
      v = (n / 800) % vt;
      return (h < 640) && (v < va);
   endfunction

   function automatic int addr_at(input int n, input int vt);
      int h, v;
      h = n % 800;
      v = (n / 800) % vt;
      return (v / 4) * 160 + h / 4;
   endfunction

   function automatic logic [7:0] x3(input int q);
      return 8'(q * 36 + q / 2);
   endfunction

   // t = clock edges since the last reset edge = current counter position.
   always @(posedge clk) begin
      if (!rst) begin
         t      <= 0;
         armed  <= 1'b1;
         a_held <= '0;
         b_held <= '0;
      end else begin
         t <= t + 1;
         if (act_at(t, 480, 525)) a_held <= 15'(addr_at(t, 525));
         if (act_at(t, 12, 19))   b_held <= 15'(addr_at(t, 19));
      end
   end

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s t=%0d got %0h want %0h", nm, t, act, exp);
      end
   endtask

   task automatic check_inst(
      input string id, input int va, input int vf, input int vs,
      input int vb, input logic [14:0] held,
      input logic [14:0] addr, input logic en,
      input logic [7:0] r, input logic [7:0] g, input logic [7:0] b,
      input logic hs, input logic vsy, input logic blank,
      input logic sb, input logic vbl, input logic fs
   );
      int vt, n, h, v;
      logic a;
      logic [7:0] p;
      vt = va + vf + vs + vb;
      v  = (t / 800) % vt;
      chk({id, " frame_start"}, 32'(fs), 32'(t % (800 * vt) == 0));
      chk({id, " vblank"}, 32'(vbl), 32'(v >= va));
      chk({id, " rd_en"}, 32'(en), 32'(t >= 1 && act_at(t - 1, va, vt)));
      chk({id, " addr"}, 32'(addr), 32'(held));
      chk({id, " sync_b"}, 32'(sb), 32'd0);
      if (t < 3) begin
         chk({id, " hs_rst"}, 32'(hs), 32'd1);
         chk({id, " vs_rst"}, 32'(vsy), 32'd1);
         chk({id, " blank_rst"}, 32'(blank), 32'd0);
         chk({id, " rgb_rst"}, {8'h0, r, g, b}, 32'd0);
      end else begin
         n = t - 3;
         h = n % 800;
         v = (n / 800) % vt;
         a = act_at(n, va, vt);
         p = a ? mem[addr_at(n, vt)] : 8'h00;
         chk({id, " hsync"}, 32'(hs), 32'(!(h >= 656 && h < 752)));
         chk({id, " vsync"}, 32'(vsy),
             32'(!(v >= va + vf && v < va + vf + vs)));
         chk({id, " blank"}, 32'(blank), 32'(a));
         chk({id, " r"}, 32'(r), a ? 32'(x3(int'(p[7:5]))) : 32'd0);
         chk({id, " g"}, 32'(g), a ? 32'(x3(int'(p[4:2]))) : 32'd0);
         chk({id, " b"}, 32'(b), a ? 32'(int'(p[1:0]) * 85) : 32'd0);
      end
   endtask

   always @(negedge clk) begin
      if (armed) begin
         check_inst("A", 480, 10, 2, 33, a_held, a_addr, a_en,
                    a_r, a_g, a_b, a_hs, a_vs, a_blank, a_sb, a_vbl, a_fs);
         check_inst("B", 12, 2, 2, 3, b_held, b_addr, b_en,
                    b_r, b_g, b_b, b_hs, b_vs, b_blank, b_sb, b_vbl, b_fs);
         case (t)
            1:     chk("lit addr h0", 32'(a_addr), 32'd0);
            2:     chk("lit blank t2", 32'(a_blank), 32'd0);
            3:     chk("lit rgb E0", {8'h0, a_r, a_g, a_b}, 32'hFF0000);
            4:     chk("lit addr h3", 32'(a_addr), 32'd0);
            5:     chk("lit addr h4", 32'(a_addr), 32'd1);
            7:     chk("lit rgb 1C", {8'h0, a_r, a_g, a_b}, 32'h00FF00);
            11:    chk("lit rgb 03", {8'h0, a_r, a_g, a_b}, 32'h0000FF);
            15:    chk("lit rgb 92", {8'h0, a_r, a_g, a_b}, 32'h9292AA);
            637:   chk("lit addr h636", 32'(a_addr), 32'd159);
            641:   chk("lit rd_en h640", 32'(a_en), 32'd0);
            642:   chk("lit blank t642", 32'(a_blank), 32'd1);
            643:   chk("lit blank t643", 32'(a_blank), 32'd0);
            658:   chk("lit hs t658", 32'(a_hs), 32'd1);
            659:   chk("lit hs t659", 32'(a_hs), 32'd0);
            700:   chk("lit rgb blank", {8'h0, a_r, a_g, a_b}, 32'd0);
            754:   chk("lit hs t754", 32'(a_hs), 32'd0);
            755:   chk("lit hs t755", 32'(a_hs), 32'd1);
            3201:  chk("lit addr line4", 32'(a_addr), 32'd160);
            9440:  chk("lit addr last", 32'(b_addr), 32'd479);
            9599:  chk("lit vblank t9599", 32'(b_vbl), 32'd0);
            9600:  chk("lit vblank t9600", 32'(b_vbl), 32'd1);
            11202: chk("lit vs t11202", 32'(b_vs), 32'd1);
            11203: chk("lit vs t11203", 32'(b_vs), 32'd0);
            12802: chk("lit vs t12802", 32'(b_vs), 32'd0);
            12803: chk("lit vs t12803", 32'(b_vs), 32'd1);
            15199: chk("lit fs t15199", 32'(b_fs), 32'd0);
            15200: chk("lit fs t15200", 32'(b_fs), 32'd1);
            default: ;
         endcase
      end
   end

   initial begin
      rst = 1'b0;
      repeat (5) @(negedge clk);
      rst = 1'b1;
      // Reset again at (h=300, v=5) of dut_b's second frame.
      repeat (19500) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      repeat (16000) @(negedge clk);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
